// File: rtl/m68k_dtack_ctrl.sv
// Wait-state sequencer for the 68000 bus: decodes the region of each bus cycle,
// inserts its configured wait states, honours the external wait line and drives nDTACK.
module m68k_dtack_ctrl #(
  parameter int unsigned WS_PROM = 0,
  parameter int unsigned WS_WRAM = 0,
  parameter int unsigned WS_PORT = 1,
  parameter int unsigned WS_IO   = 1,
  parameter int unsigned WS_PAL  = 1,
  parameter int unsigned WS_CARD = 2,
  parameter int unsigned WS_BIOS = 0,
  parameter int unsigned WS_SRAM = 0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK_68KCLK,
  input  logic        RESET,
  input  logic        nAS,
  input  logic [23:1] M68K_ADDR,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        M68K_RW,
  input  logic        nWAIT_EXT,
  output logic        nDTACK,
  output logic [2:0]  REGION,
  output logic        BUSY,
  output logic        TIMEOUT_P
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_r, state_nx;
  logic [7:0] wcnt_r, wcnt_nx, wcnt_dec_s;
  logic [7:0] wdog_r, wdog_nx;
  logic [2:0] region_nx;
  logic       tmo_nx;

  // Strobes and direction have no influence on acknowledge timing.
  logic unused_ok;
  assign unused_ok = &{1'b0, nUDS, nLDS, M68K_RW, M68K_ADDR[19:1]};

  function automatic logic [2:0] region_of(input logic [3:0] hi);
    case (hi)
      4'h0:                      region_of = 3'd0;
      4'h1:                      region_of = 3'd1;
      4'h2:                      region_of = 3'd2;
      4'h3:                      region_of = 3'd3;
      4'h4, 4'h5, 4'h6, 4'h7:    region_of = 3'd4;
      4'h8, 4'h9, 4'hA, 4'hB:    region_of = 3'd5;
      4'hC:                      region_of = 3'd6;
      default:                   region_of = 3'd7;
    endcase
  endfunction

  function automatic logic [7:0] ws_of(input logic [2:0] r);
    case (r)
      3'd0:    ws_of = 8'(WS_PROM);
      3'd1:    ws_of = 8'(WS_WRAM);
      3'd2:    ws_of = 8'(WS_PORT);
      3'd3:    ws_of = 8'(WS_IO);
      3'd4:    ws_of = 8'(WS_PAL);
      3'd5:    ws_of = 8'(WS_CARD);
      3'd6:    ws_of = 8'(WS_BIOS);
      default: ws_of = 8'(WS_SRAM);
    endcase
  endfunction

  assign wcnt_dec_s = (wcnt_r == 8'd0) ? 8'd0 : wcnt_r - 8'd1;

  // Next-state, counter and pulse logic; transitions use the decremented wait count.
  always_comb begin
    state_nx  = state_r;
    wcnt_nx   = wcnt_r;
    wdog_nx   = wdog_r;
    region_nx = REGION;
    tmo_nx    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!nAS) begin
          region_nx = region_of(M68K_ADDR[23:20]);
          wcnt_nx   = ws_of(region_nx);
          wdog_nx   = 8'd0;
          if ((wcnt_nx == 8'd0) && nWAIT_EXT) begin
            state_nx = ST_ACK;
          end else begin
            state_nx = ST_WAIT;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        wcnt_nx = wcnt_dec_s;
        wdog_nx = wdog_r + 8'd1;
        if (nAS) begin
          state_nx = ST_IDLE;
        end else if (wdog_r == TMO_LAST) begin
          state_nx = ST_ACK;
          tmo_nx   = 1'b1;
        end else if ((wcnt_dec_s == 8'd0) && nWAIT_EXT) begin
          state_nx = ST_ACK;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_ACK: begin
        if (nAS) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ACK;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs, all derived from the next state.
  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      wcnt_r    <= 8'd0;
      wdog_r    <= 8'd0;
      REGION    <= 3'd0;
      nDTACK    <= 1'b1;
      BUSY      <= 1'b0;
      TIMEOUT_P <= 1'b0;
    end else begin
      state_r   <= state_nx;
      wcnt_r    <= wcnt_nx;
      wdog_r    <= wdog_nx;
      REGION    <= region_nx;
      nDTACK    <= (state_nx != ST_ACK);
      BUSY      <= (state_nx != ST_IDLE);
      TIMEOUT_P <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_m68k_dtack_ctrl.sv
// Directed bench for m68k_dtack_ctrl: a cycle-level latency model checked every clock,
// plus hand-computed expectations at the points the scenarios call out.
module tb_m68k_dtack_ctrl;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nas = 1'b1;
  logic [23:0] addr = 24'h0;
  logic        nuds = 1'b1;
  logic        nlds = 1'b1;
  logic        rw = 1'b1;
  logic        nwait = 1'b1;
  logic        ndtack;
  logic [2:0]  region;
  logic        busy;
  logic        tmo_p;

  int n_checks = 0;
  int n_fail = 0;

  int ws_tbl [8] = '{0, 0, 1, 1, 1, 2, 0, 0};

  // Model: cycle start, edges elapsed since start, acknowledge status.
  logic m_busy = 1'b0;
  logic m_ack = 1'b0;
  logic m_tp = 1'b0;
  int   m_region = 0;
  int   m_ws = 0;
  int   m_k = 0;

  m68k_dtack_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK_68KCLK(clk),
    .RESET(rst),
    .nAS(nas),
    .M68K_ADDR(addr[23:1]),
    .nUDS(nuds),
    .nLDS(nlds),
    .M68K_RW(rw),
    .nWAIT_EXT(nwait),
    .nDTACK(ndtack),
    .REGION(region),
    .BUSY(busy),
    .TIMEOUT_P(tmo_p)
  );

  always #5 clk = ~clk;

  function automatic int exp_region(input logic [23:0] a);
    int hi;
    hi = int'(a[23:20]);
    if (hi < 4) return hi;
    else if (hi < 8) return 4;
    else if (hi < 12) return 5;
    else if (hi == 12) return 6;
    else return 7;
  endfunction

  // Acknowledge comes at edge N+k once k >= WS and the wait line is high, or at k == TIMEOUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_ack <= 1'b0; m_tp <= 1'b0; m_region <= 0; m_k <= 0;
    end else begin
      m_tp <= 1'b0;
      if (!m_busy) begin
        if (!nas) begin
          m_busy   <= 1'b1;
          m_region <= exp_region(addr);
          m_ws     <= ws_tbl[exp_region(addr)];
          m_k      <= 0;
          m_ack    <= (ws_tbl[exp_region(addr)] == 0) && nwait;
        end
      end else if (m_ack) begin
        if (nas) begin
          m_busy <= 1'b0; m_ack <= 1'b0;
        end
      end else begin
        m_k <= m_k + 1;
        if (nas) begin
          m_busy <= 1'b0;
        end else if (m_k + 1 == TMO) begin
          m_ack <= 1'b1; m_tp <= 1'b1;
        end else if ((m_k + 1 >= m_ws) && nwait) begin
          m_ack <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model comparison on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_ndtack", int'(ndtack), int'(!m_ack));
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_region", int'(region), m_region);
      chk("model_timeout_p", int'(tmo_p), int'(m_tp));
    end
  end

  typedef struct { logic [23:0] a; int r; int ws; } sweep_t;
  sweep_t sweep [5];

  initial begin
    int cnt;
    sweep[0] = '{24'h000000, 0, 0};
    sweep[1] = '{24'h3C0000, 3, 1};
    sweep[2] = '{24'h400000, 4, 1};
    sweep[3] = '{24'hD00000, 7, 0};
    sweep[4] = '{24'hF00000, 7, 0};

    tick(3);
    chk("rst_ndtack", int'(ndtack), 1);
    chk("rst_region", int'(region), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tp", int'(tmo_p), 0);
    rst = 1'b0;
    tick(2);

    // WRAM, no wait states
    addr = 24'h100000; nas = 1'b0;
    tick(1);
    chk("wram_ndtack", int'(ndtack), 0);
    chk("wram_region", int'(region), 1);
    chk("wram_busy", int'(busy), 1);
    nas = 1'b1;
    tick(1);
    chk("wram_end_ndtack", int'(ndtack), 1);
    chk("wram_end_busy", int'(busy), 0);

    // Memory card, two wait states
    addr = 24'h800000; nas = 1'b0;
    tick(2);
    chk("card_n1_ndtack", int'(ndtack), 1);
    tick(1);
    chk("card_n2_ndtack", int'(ndtack), 0);
    chk("card_region", int'(region), 5);
    nas = 1'b1;
    tick(1);

    // Card with wait line low from before N through edge N+4
    nas = 1'b0; nwait = 1'b0;
    tick(5);
    chk("cardw_n4_ndtack", int'(ndtack), 1);
    nwait = 1'b1;
    tick(1);
    chk("cardw_n5_ndtack", int'(ndtack), 0);
    nas = 1'b1;
    tick(1);

    // Card with wait line low for edges N..N+2 only
    nas = 1'b0; nwait = 1'b0;
    tick(3);
    nwait = 1'b1;
    chk("cardw3_n2_ndtack", int'(ndtack), 1);
    tick(1);
    chk("cardw3_n3_ndtack", int'(ndtack), 0);
    nas = 1'b1;
    tick(1);

    // Watchdog
    addr = 24'h200000; nas = 1'b0; nwait = 1'b0;
    tick(TMO);
    chk("wdog_n19_ndtack", int'(ndtack), 1);
    chk("wdog_n19_tp", int'(tmo_p), 0);
    tick(1);
    chk("wdog_n20_ndtack", int'(ndtack), 0);
    chk("wdog_n20_tp", int'(tmo_p), 1);
    tick(1);
    chk("wdog_n21_tp", int'(tmo_p), 0);
    nas = 1'b1; nwait = 1'b1;
    tick(1);
    chk("wdog_end_ndtack", int'(ndtack), 1);
    chk("wdog_end_busy", int'(busy), 0);

    // Abort during wait, then BIOS access
    addr = 24'h800000; nas = 1'b0;
    tick(2);
    nas = 1'b1;
    tick(1);
    chk("abort_ndtack", int'(ndtack), 1);
    chk("abort_busy", int'(busy), 0);
    addr = 24'hC00000; nas = 1'b0;
    tick(1);
    chk("bios_region", int'(region), 6);
    chk("bios_ndtack", int'(ndtack), 0);
    nas = 1'b1;
    tick(1);

    // Reset while in ACK, released with nAS still low
    addr = 24'h000000; rw = 1'b0; nas = 1'b0;
    tick(1);
    chk("rmid_pre_ndtack", int'(ndtack), 0);
    #2 rst = 1'b1;
    #1;
    chk("rmid_ndtack", int'(ndtack), 1);
    chk("rmid_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("rmid_restart_ndtack", int'(ndtack), 0);
    chk("rmid_restart_busy", int'(busy), 1);
    nas = 1'b1; rw = 1'b1;
    tick(1);

    // Back-to-back address sweep
    for (int i = 0; i < 5; i++) begin
      addr = sweep[i].a; nas = 1'b0;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (ndtack && cnt < 10);
      chk("sweep_latency", cnt, sweep[i].ws + 1);
      chk("sweep_region", int'(region), sweep[i].r);
      nas = 1'b1;
      tick(1);
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
